activation: RTL and testbench

Downstream stage of the per-layer multiply-accumulate block. Takes NC signed accumulated sums per transaction, applies optional rounding right shift, ReLU and unsigned saturation to WD bits, and delivers NC activations to the next layer's input bus. A 2-entry output buffer gives full throughput under valid/ready back-pressure.

---
 rtl/activation.sv | 112 +++++++++++
 tb/tb_activation.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/activation.sv
// Activation stage: per-lane rounding shift, ReLU and unsigned clamp of MAC sums,
// followed by a 2-entry valid/ready output buffer for full-rate streaming.
module activation #(
  parameter int unsigned NP = 4,
  parameter int unsigned NC = 4,
  parameter int unsigned WD = 4,
  parameter int unsigned SH = 0,
  localparam int unsigned WA = $clog2(NP) + 1 + WD
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AS,
  output logic             oReady_AS,
  input  logic [NC*WA-1:0] iData_AS,
  output logic             oValid_BS,
  input  logic             iReady_BS,
  output logic [NC*WD-1:0] oData_BS
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [NC*WD-1:0] head, headNext;
  logic [NC*WD-1:0] tail, tailNext;
  logic [NC*WD-1:0] newEntry;
  logic             validQ, readyQ;
  logic             push, pop;

  // Per-lane shift/ReLU/clamp on the incoming sums
  for (genvar i = 0; i < NC; i++) begin : gLane
    localparam logic signed [WA:0] MAXV = (WA+1)'((1 << WD) - 1);
    logic signed [WA:0] x, r;
    logic [WD-1:0]      y;

    assign x = {iData_AS[i*WA + WA - 1], iData_AS[i*WA +: WA]};

    if (SH > 0) begin : gRnd
      localparam logic signed [WA:0] RND = (WA+1)'(1) << (SH - 1);
      assign r = (x + RND) >>> SH;
    end else begin : gNoRnd
      assign r = x;
    end

    always_comb begin
      y = r[WD-1:0];
      if (r < 0)          y = '0;
      else if (r > MAXV)  y = '1;
    end

    assign newEntry[i*WD +: WD] = y;
  end

  assign push = iValid_AS && readyQ;
  assign pop  = validQ && iReady_BS;

  // Buffer occupancy and entry movement
  always_comb begin
    stateNext = state;
    headNext  = head;
    tailNext  = tail;
    case (state)
      EMPTY: begin
        if (push) begin
          stateNext = ONE;
          headNext  = newEntry;
        end
      end
      ONE: begin
        if (push && pop) begin
          headNext = newEntry;
        end else if (push) begin
          tailNext  = newEntry;
          stateNext = FULL;
        end else if (pop) begin
          stateNext = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          headNext  = tail;
          stateNext = ONE;
        end
      end
      default: stateNext = EMPTY;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state  <= EMPTY;
      head   <= '0;
      tail   <= '0;
      validQ <= 1'b0;
      readyQ <= 1'b1;
    end else begin
      state  <= stateNext;
      head   <= headNext;
      tail   <= tailNext;
      validQ <= (stateNext != EMPTY);
      readyQ <= (stateNext != FULL);
    end
  end

  assign oValid_BS = validQ;
  assign oReady_AS = readyQ;
  assign oData_BS  = head;

endmodule

// File: tb/tb_activation.sv
// Scoreboard bench for activation: two instances (SH=0 and SH=2) share stimulus,
// a reference model predicts each accepted transaction and the buffer occupancy.
module tb_activation;

  localparam int unsigned NC = 2;
  localparam int unsigned WD = 4;
  localparam int unsigned WA = 7;
  localparam int unsigned DW = NC * WA;
  localparam int unsigned OW = NC * WD;

  logic          iClk = 1'b0;
  logic          iRst = 1'b0;
  logic          valid = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] data = '0;
  logic          rdy0, val0, rdy2, val2;
  logic [OW-1:0] dat0, dat2;

  int nPass = 0;
  int nChecks = 0;
  logic [OW-1:0] q0[$];
  logic [OW-1:0] q2[$];

  always #5 iClk = ~iClk;

  activation #(.NP(4), .NC(NC), .WD(WD), .SH(0)) u0 (
    .iCLK(iClk), .iRST(iRst), .iValid_AS(valid), .oReady_AS(rdy0), .iData_AS(data),
    .oValid_BS(val0), .iReady_BS(ready), .oData_BS(dat0));

  activation #(.NP(4), .NC(NC), .WD(WD), .SH(2)) u2 (
    .iCLK(iClk), .iRST(iRst), .iValid_AS(valid), .oReady_AS(rdy2), .iData_AS(data),
    .oValid_BS(val2), .iReady_BS(ready), .oData_BS(dat2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [OW-1:0] model(input logic [DW-1:0] d, input int sh);
    logic [OW-1:0] o;
    o = '0;
    for (int i = 0; i < NC; i++) begin
      int x, r;
      x = int'($signed(d[i*WA +: WA]));
      r = (sh > 0) ? ((x + (1 << (sh - 1))) >>> sh) : x;
      if (r < 0)       r = 0;
      else if (r > 15) r = 15;
      o[i*WD +: WD] = WD'(r);
    end
    return o;
  endfunction

  task automatic setData(input int a, input int b);
    data = {WA'(b), WA'(a)};
  endtask

  // One clock of the scoreboard: check head, take the edge, update model, check flags
  task automatic cycle();
    bit push, pop;
    logic [DW-1:0] snap;
    push = valid && (q0.size() != 2);
    pop  = ready && (q0.size() != 0);
    snap = data;
    if (q0.size() != 0) begin
      chk("head_sh0", 32'(dat0), 32'(q0[0]));
      chk("head_sh2", 32'(dat2), 32'(q2[0]));
    end
    @(posedge iClk);
    #1;
    if (pop) begin
      void'(q0.pop_front());
      void'(q2.pop_front());
    end
    if (push) begin
      q0.push_back(model(snap, 0));
      q2.push_back(model(snap, 2));
    end
    chk("valid_sh0", 32'(val0), 32'(q0.size() != 0));
    chk("ready_sh0", 32'(rdy0), 32'(q0.size() != 2));
    chk("valid_sh2", 32'(val2), 32'(q2.size() != 0));
    chk("ready_sh2", 32'(rdy2), 32'(q2.size() != 2));
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_valid"}, 32'(val0), 32'd0);
    chk({tag, "_ready"}, 32'(rdy0), 32'd1);
    chk({tag, "_data"},  32'(dat0), 32'd0);
    chk({tag, "_valid2"}, 32'(val2), 32'd0);
    chk({tag, "_data2"},  32'(dat2), 32'd0);
  endtask

  initial begin
    // Reset held with random inputs
    iRst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid = 1'($urandom);
      ready = 1'($urandom);
      data  = DW'($urandom);
      @(posedge iClk);
      #1;
      chkReset("reset");
    end
    iRst = 1'b1;
    valid = 1'b1; ready = 1'b0; setData(3, 4);
    cycle();
    valid = 1'b0; ready = 1'b1;
    cycle();

    // ReLU / clamp / rounding back to back
    valid = 1'b1; ready = 1'b1;
    setData(-5, 9);  cycle();
    setData(63, -64); cycle();
    setData(15, 16); cycle();
    setData(6, 5);   cycle();
    setData(-2, -3); cycle();
    setData(62, 61); cycle();
    valid = 1'b0;
    cycle(); cycle();

    // Back-pressure: fill, hold while offering a third entry, then drain
    ready = 1'b0; valid = 1'b1;
    setData(10, 20); cycle();
    setData(30, -7); cycle();
    setData(1, 2);   cycle(); cycle();
    valid = 1'b0; ready = 1'b1;
    cycle(); cycle(); cycle();

    // Simultaneous push/pop with one entry held
    valid = 1'b1; ready = 1'b0; setData(7, 8);
    cycle();
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = DW'($urandom);
      cycle();
    end
    valid = 1'b0;
    cycle(); cycle();

    // Mid-operation reset with the buffer full
    ready = 1'b0; valid = 1'b1;
    setData(11, 12); cycle();
    setData(13, 14); cycle();
    valid = 1'b0;
    #2 iRst = 1'b0;
    #1 chkReset("midreset");
    #2 iRst = 1'b1;
    q0.delete();
    q2.delete();
    ready = 1'b1;
    cycle(); cycle();
    valid = 1'b1; setData(5, 50);
    cycle();
    valid = 1'b0;
    cycle(); cycle();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
